// File: rtl/knn_pkg.sv
// Shared types and constants for the KNN k-sorter control path.
package knn_pkg;

    // Query sequencing states for the sorter controller.
    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        LOAD,
        SETTLE,
        CAPTURE,
        PRESENT,
        ADV_A,
        ADV_B,
        FINISH
    } state_e;

    localparam int unsigned MAX_MEMORY_DEF = 64;
    localparam int unsigned VAL_WIDTH_DEF  = 32;

    // An unused sorter slot reads back as all ones.
    localparam logic [VAL_WIDTH_DEF-1:0] SENTINEL = {VAL_WIDTH_DEF{1'b1}};

    // k can never exceed the number of physical sorter slots.
    function automatic logic [31:0] clamp_k(input logic [31:0] k, input logic [31:0] max_mem);
        return (k > max_mem) ? max_mem : k;
    endfunction

endpackage

// File: rtl/knn_sort_ctrl.sv
// Per-query sequencer for one k-sorting insertion array: clear, stream N
// distances in, then drain the k best (name,value) pairs on a ready/valid port.
module knn_sort_ctrl
    import knn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VAL_WIDTH  = 32,
    parameter int MAX_MEMORY = MAX_MEMORY_DEF,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           k_cfg,
    input  logic [CNT_WIDTH-1:0]  num_points,
    input  logic                  dist_valid,
    input  logic [VAL_WIDTH-1:0]  dist_data,
    output logic                  dist_ready,
    output logic                  srt_reset,
    output logic                  srt_wr_en,
    output logic                  srt_valid,
    output logic [VAL_WIDTH-1:0]  srt_value,
    output logic                  srt_rd_en,
    output logic                  srt_done,
    output logic [31:0]           srt_k,
    input  logic [DATA_WIDTH-1:0] srt_name,
    input  logic [VAL_WIDTH-1:0]  srt_val,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_name,
    output logic [VAL_WIDTH-1:0]  res_value,
    output logic                  res_last,
    output logic                  busy,
    output logic                  query_done
);

    state_e                  state_q, state_d;
    logic                    abort_q, abort_d;      // current CLEAR was caused by abort
    logic [31:0]             k_lat_q, k_lat_d;
    logic [CNT_WIDTH-1:0]    n_lat_q, n_lat_d;
    logic [CNT_WIDTH-1:0]    pts_q, pts_d;
    logic [31:0]             idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   res_name_q, res_name_d;
    logic [VAL_WIDTH-1:0]    res_value_q, res_value_d;
    logic                    res_last_q, res_last_d;
    logic                    beat;

    assign srt_value = dist_data;
    assign srt_k     = k_lat_q;
    assign res_name  = res_name_q;
    assign res_value = res_value_q;
    assign res_last  = res_last_q;

    // Next-state, counter/latch updates and all sorter/result control outputs.
    always_comb begin
        state_d     = state_q;
        abort_d     = abort_q;
        k_lat_d     = k_lat_q;
        n_lat_d     = n_lat_q;
        pts_d       = pts_q;
        idx_d       = idx_q;
        res_name_d  = res_name_q;
        res_value_d = res_value_q;
        res_last_d  = res_last_q;

        dist_ready  = (state_q == LOAD);
        beat        = dist_ready && dist_valid;
        srt_wr_en   = beat;
        srt_valid   = beat;
        srt_reset   = reset || (state_q == CLEAR);
        srt_rd_en   = (state_q == ADV_A) || (state_q == ADV_B);
        srt_done    = (state_q == SETTLE) || (state_q == CAPTURE) || (state_q == PRESENT) ||
                      (state_q == ADV_A)  || (state_q == ADV_B)   || (state_q == FINISH);
        res_valid   = (state_q == PRESENT);
        busy        = (state_q != IDLE);
        query_done  = (state_q == FINISH) && !abort;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = CLEAR;
                    abort_d = 1'b0;
                    k_lat_d = clamp_k(k_cfg, 32'(MAX_MEMORY));
                    n_lat_d = num_points;
                end
            end
            CLEAR: begin
                pts_d = '0;
                idx_d = '0;
                if (abort_q)            state_d = IDLE;
                else if (n_lat_q == '0) state_d = SETTLE;
                else                    state_d = LOAD;
            end
            LOAD: begin
                if (beat) begin
                    pts_d = pts_q + CNT_WIDTH'(1);
                    if (pts_q == n_lat_q - CNT_WIDTH'(1)) state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = (k_lat_q == 32'd0) ? FINISH : CAPTURE;
            end
            CAPTURE: begin
                res_name_d  = srt_name;
                res_value_d = srt_val;
                res_last_d  = (idx_q == k_lat_q - 32'd1);
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (res_ready) state_d = res_last_q ? FINISH : ADV_A;
            end
            ADV_A: begin
                state_d = ADV_B;
            end
            ADV_B: begin
                if (idx_q != k_lat_q - 32'd1) idx_d = idx_q + 32'd1;
                state_d = CAPTURE;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides any in-flight transition and forces one clearing cycle.
        if (abort && (state_q != IDLE)) begin
            state_d = CLEAR;
            abort_d = 1'b1;
        end
    end

    // State, latched configuration, counters and the result register slice.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            abort_q     <= 1'b0;
            k_lat_q     <= '0;
            n_lat_q     <= '0;
            pts_q       <= '0;
            idx_q       <= '0;
            res_name_q  <= '0;
            res_value_q <= '0;
            res_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            abort_q     <= abort_d;
            k_lat_q     <= k_lat_d;
            n_lat_q     <= n_lat_d;
            pts_q       <= pts_d;
            idx_q       <= idx_d;
            res_name_q  <= res_name_d;
            res_value_q <= res_value_d;
            res_last_q  <= res_last_d;
        end
    end

endmodule

// File: tb/tb_knn_sort_ctrl.sv
// Scoreboard bench for knn_sort_ctrl with a behavioural insertion-sorter model.
module tb_knn_sort_ctrl;
    import knn_pkg::*;

    localparam int DW = 32;
    localparam int VW = 32;
    localparam int MM = 64;
    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, abort;
    logic [31:0]   k_cfg;
    logic [CW-1:0] num_points;
    logic          dist_valid;
    logic [VW-1:0] dist_data;
    logic          dist_ready, srt_reset, srt_wr_en, srt_valid;
    logic [VW-1:0] srt_value;
    logic          srt_rd_en, srt_done;
    logic [31:0]   srt_k;
    logic [DW-1:0] srt_name;
    logic [VW-1:0] srt_val;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_name;
    logic [VW-1:0] res_value;
    logic          res_last, busy, query_done;

    knn_sort_ctrl #(.DATA_WIDTH(DW), .VAL_WIDTH(VW), .MAX_MEMORY(MM), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .k_cfg(k_cfg),
        .num_points(num_points), .dist_valid(dist_valid), .dist_data(dist_data),
        .dist_ready(dist_ready), .srt_reset(srt_reset), .srt_wr_en(srt_wr_en),
        .srt_valid(srt_valid), .srt_value(srt_value), .srt_rd_en(srt_rd_en),
        .srt_done(srt_done), .srt_k(srt_k), .srt_name(srt_name), .srt_val(srt_val),
        .res_valid(res_valid), .res_ready(res_ready), .res_name(res_name),
        .res_value(res_value), .res_last(res_last), .busy(busy), .query_done(query_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- sorter model: stable ascending insertion, 2 rd_en per step
    logic [31:0] m_name [MM];
    logic [31:0] m_val  [MM];
    int m_cnt = 0, ins_cnt = 0, rd_cnt = 0;

    initial forever begin : sorter_model
        logic s_rst, s_ins, s_rd;
        logic [31:0] s_v;
        int pos;
        @(negedge clk);
        s_rst = srt_reset;
        s_ins = srt_wr_en && srt_valid;
        s_v   = srt_value;
        s_rd  = srt_rd_en && srt_done;
        @(posedge clk);
        #1;
        if (s_rst) begin
            m_cnt = 0; ins_cnt = 0; rd_cnt = 0;
        end else begin
            if (s_ins) begin
                pos = 0;
                while (pos < m_cnt && m_val[pos] <= s_v) pos++;
                if (pos < MM) begin
                    for (int j = MM - 1; j > pos; j--) begin
                        m_val[j]  = m_val[j-1];
                        m_name[j] = m_name[j-1];
                    end
                    m_val[pos]  = s_v;
                    m_name[pos] = ins_cnt;
                    if (m_cnt < MM) m_cnt++;
                end
                ins_cnt++;
            end
            if (s_rd) rd_cnt++;
        end
    end

    always_comb begin
        srt_name = '1;
        srt_val  = '1;
        if ((rd_cnt / 2) < m_cnt) begin
            srt_name = m_name[rd_cnt / 2];
            srt_val  = m_val[rd_cnt / 2];
        end
    end

    // ---------------- scoreboard
    typedef struct {
        logic [31:0] name;
        logic [31:0] val;
        logic        last;
    } beat_t;
    beat_t exp_q[$];

    int first_ready_cyc = -1, first_rv_cyc = -1, last_beat_cyc = -1, qdone_cyc = -1;
    int qdone_cnt = 0, beats_acc = 0, start_cyc = 0;
    int hs_q[$];

    task automatic push(input logic [31:0] nm, input logic [31:0] vl, input logic ls);
        beat_t b;
        b.name = nm; b.val = vl; b.last = ls;
        exp_q.push_back(b);
    endtask

    task automatic clear_trk();
        first_ready_cyc = -1; first_rv_cyc = -1; last_beat_cyc = -1; qdone_cyc = -1;
        beats_acc = 0;
        hs_q.delete();
    endtask

    initial forever begin : monitor
        beat_t e;
        @(negedge clk);
        if (!reset) begin
            if (dist_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
            if (dist_valid && dist_ready) begin
                last_beat_cyc = cyc;
                beats_acc++;
            end
            if (res_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
            if (query_done) begin
                qdone_cnt++;
                qdone_cyc = cyc;
            end
            if (res_valid && res_ready) begin
                hs_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {res_name, res_value}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_name", res_name, e.name);
                    chk("beat_value", res_value, e.val);
                    chk("beat_last", res_last, e.last);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (called aligned to posedge+1)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] k, input logic [31:0] n);
        start = 1'b1; k_cfg = k; num_points = n; start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int vals[$], input int gap);
        logic acc;
        foreach (vals[i]) begin
            dist_valid = 1'b1;
            dist_data  = vals[i];
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk);
                acc = dist_ready;
                tick();
            end
            dist_valid = 1'b0;
            if (!acc) chk("feed_timeout", acc, 1);
            repeat (gap) tick();
        end
    endtask

    task automatic wait_idle(input int maxc);
        for (int t = 0; t < maxc; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", busy, 0);
        tick();
    endtask

    task automatic wait_rv(input int maxc);
        for (int t = 0; t < maxc; t++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        chk("res_valid_timeout", res_valid, 1);
    endtask

    task automatic run_q(input logic [31:0] k, input logic [31:0] n, input int vals[$], input int gap);
        int qd0;
        clear_trk();
        qd0 = qdone_cnt;
        do_start(k, n);
        feed(vals, gap);
        wait_idle(1000);
        chk("queue_drained", exp_q.size(), 0);
        chk("query_done_count", qdone_cnt - qd0, 1);
    endtask

    task automatic push_t1();
        push(1, 2, 0); push(3, 2, 0); push(4, 5, 1);
    endtask

    // ---------------- directed sequence
    initial begin
        int v[$];
        int qd0;
        logic [DW-1:0] sn;
        logic [VW-1:0] sv;
        logic sl, stable, rd_seen;

        reset = 1'b1; start = 1'b0; abort = 1'b0; k_cfg = '0; num_points = '0;
        dist_valid = 1'b0; dist_data = '0; res_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_ctrl_outs", {busy, res_valid, dist_ready, query_done, srt_done,
                                srt_rd_en, srt_wr_en, srt_valid, res_last}, 0);
        chk("reset_srt_reset", srt_reset, 1);
        chk("reset_data_outs", {srt_k, res_name, res_value}, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("srt_reset_released", srt_reset, 0);
        tick();

        // 1: k=3, N=5 with latency checks
        push_t1();
        v = {9, 2, 7, 2, 5};
        run_q(3, 5, v, 0);
        chk("start_to_ready", first_ready_cyc - start_cyc, 2);
        chk("lastbeat_to_rvalid", first_rv_cyc - last_beat_cyc, 3);
        chk("hs_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            chk("beat_gap1", hs_q[1] - hs_q[0], 4);
            chk("beat_gap2", hs_q[2] - hs_q[1], 4);
            chk("done_after_last", qdone_cyc - hs_q[2], 1);
        end

        // 2: k=4, N=2 -> two real beats then two sentinels
        push(1, 1, 0); push(0, 6, 0); push(SENTINEL, SENTINEL, 0); push(SENTINEL, SENTINEL, 1);
        v = {6, 1};
        run_q(4, 2, v, 0);

        // 3a: k=0, N=0 -> no beats, done 3 cycles after start
        v = {};
        run_q(0, 0, v, 0);
        chk("k0_done_latency", qdone_cyc - start_cyc, 3);
        chk("k0_no_result", first_rv_cyc, -1);

        // 3b: N=0, k=2 -> two sentinel beats
        push(SENTINEL, SENTINEL, 0); push(SENTINEL, SENTINEL, 1);
        run_q(2, 0, v, 0);

        // 4: k clamp to 64 with 70 permuted distances
        v = {};
        for (int i = 0; i < 70; i++) v.push_back((i * 29) % 70);
        for (int vv = 0; vv < 64; vv++)
            for (int i = 0; i < 70; i++)
                if ((i * 29) % 70 == vv) push(i, vv, vv == 63);
        run_q(100, 70, v, 0);
        chk("srt_k_clamped", srt_k, 64);

        // 5: dist_valid gaps and a 10-cycle res_ready stall
        res_ready = 1'b0;
        clear_trk();
        qd0 = qdone_cnt;
        push(1, 3, 0); push(0, 5, 1);
        v = {5, 3, 8};
        do_start(2, 3);
        feed(v, 2);
        wait_rv(50);
        sn = res_name; sv = res_value; sl = res_last;
        stable = 1'b1; rd_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if ({res_valid, res_name, res_value, res_last} != {1'b1, sn, sv, sl}) stable = 1'b0;
            if (srt_rd_en) rd_seen = 1'b1;
        end
        chk("present_stable", stable, 1);
        chk("no_rd_while_stalled", rd_seen, 0);
        tick();
        res_ready = 1'b1;
        wait_idle(200);
        chk("stall_queue_drained", exp_q.size(), 0);
        chk("stall_done_count", qdone_cnt - qd0, 1);
        chk("beats_accepted", beats_acc, 3);

        // 6a: abort during LOAD
        clear_trk();
        qd0 = qdone_cnt;
        v = {4, 3};
        do_start(2, 4);
        feed(v, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_load_clear", srt_reset, 1);
        @(negedge clk);
        chk("abort_load_idle", busy, 0);
        tick();
        chk("abort_load_no_done", qdone_cnt - qd0, 0);
        chk("abort_load_no_result", first_rv_cyc, -1);

        // start coincident with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1; k_cfg = 3; num_points = 5;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_with_abort_ignored", busy, 0);
        tick();

        // follow-up query, with a stray start while busy
        clear_trk();
        qd0 = qdone_cnt;
        push_t1();
        v = {9, 2, 7, 2, 5};
        do_start(3, 5);
        start = 1'b1; k_cfg = 1; num_points = 1;
        tick();
        start = 1'b0;
        feed(v, 0);
        wait_idle(200);
        chk("after_abort_drained", exp_q.size(), 0);
        chk("after_abort_done", qdone_cnt - qd0, 1);

        // 6b: abort during PRESENT
        res_ready = 1'b0;
        clear_trk();
        qd0 = qdone_cnt;
        v = {7, 1};
        do_start(2, 2);
        feed(v, 0);
        wait_rv(20);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_present_rv_drop", res_valid, 0);
        chk("abort_present_clear", srt_reset, 1);
        @(negedge clk);
        chk("abort_present_idle", busy, 0);
        tick();
        res_ready = 1'b1;
        chk("abort_present_no_done", qdone_cnt - qd0, 0);
        push(1, 1, 0); push(0, 6, 0); push(SENTINEL, SENTINEL, 0); push(SENTINEL, SENTINEL, 1);
        v = {6, 1};
        run_q(4, 2, v, 0);

        // 6c: reset during LOAD
        clear_trk();
        v = {4, 3};
        do_start(2, 4);
        feed(v, 0);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("reset_load_idle", busy, 0);
        chk("reset_load_srt_reset", srt_reset, 1);
        tick();
        reset = 1'b0;
        tick();
        push_t1();
        v = {9, 2, 7, 2, 5};
        run_q(3, 5, v, 0);

        // 6d: reset during PRESENT
        res_ready = 1'b0;
        clear_trk();
        v = {7, 1};
        do_start(2, 2);
        feed(v, 0);
        wait_rv(20);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("reset_present_rv_drop", res_valid, 0);
        chk("reset_present_idle", busy, 0);
        tick();
        reset = 1'b0;
        res_ready = 1'b1;
        tick();
        push(SENTINEL, SENTINEL, 0); push(SENTINEL, SENTINEL, 1);
        v = {};
        run_q(2, 0, v, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
